psram_spi_responder: RTL and testbench

- Synthesizable SPI-mode responder that emulates the serial PSRAM device as seen by our PSRAM initiator.
- Sits on the far side of the SPI pins (ce_n / clk / sio[0] / sio[1]); used for on-FPGA loopback bring-up and as the bench target for initiator regressions.
- Oversamples the SPI pins on sys_clk and serves reset, read ID, write and read commands from a small internal byte array.

---
 rtl/psram_spi_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_psram_spi_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/psram_spi_responder.sv
// ============================================================================
//  Module   : psram_spi_responder
//  Purpose  : Mode-0 SPI responder that emulates a serial PSRAM. It oversamples
//             the SPI pins on sys_clk and serves the reset, read ID, write and
//             read commands from an internal byte array.
//             Optional fast read (0x0B) is enabled by defining PSRAM_FAST_READ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psram_spi_responder #(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] MF_ID  = 8'h0D,
    parameter logic [7:0] KGD_ID = 8'h5D
) (
    input  logic sys_clk,
    input  logic sys_reset_n,
    input  logic ce_n,
    input  logic sclk,
    input  logic si,
    output logic so,
    output logic so_oe,
    output logic busy,
    output logic rst_evt,
    output logic cmd_err
);

    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_ID, S_IGNORE
    } state_t;

    typedef enum logic [1:0] {K_RD, K_WR, K_ID, K_FRD} kind_t;

    logic [1:0]        ce_sync_q;
    logic [2:0]        sclk_sync_q;
    logic [1:0]        si_sync_q;

    state_t            state_q;
    kind_t             kind_q;
    logic [4:0]        bitcnt_q;
    logic [6:0]        sh_q;
    logic [ADDR_W-2:0] addr_sh_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [6:0]        out_sh_q;
    logic [2:0]        outcnt_q;
    logic [1:0]        id_idx_q;
    logic              reset_armed_q;
    logic              so_q, so_oe_q, busy_q, rst_evt_q, cmd_err_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        mem [DEPTH];

    logic              ce_s, sclk_rise, sclk_fall, si_s;
    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] addr_in;
    logic [7:0]        out_byte;

    assign ce_s      = ce_sync_q[1];
    assign si_s      = si_sync_q[1];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign byte_in   = {sh_q, si_s};
    assign addr_in   = {addr_sh_q, si_s};

    always_comb begin
        out_byte = mem[ptr_q];
        if (state_q == S_ID) begin
            case (id_idx_q)
                2'd0:    out_byte = MF_ID;
                2'd1:    out_byte = KGD_ID;
                default: out_byte = 8'h00;
            endcase
        end
    end

    // ce_n resets to the inactive (high) level so reset never looks like a frame start.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            ce_sync_q   <= 2'b11;
            sclk_sync_q <= '0;
            si_sync_q   <= '0;
        end else begin
            ce_sync_q   <= {ce_sync_q[0], ce_n};
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            si_sync_q   <= {si_sync_q[0], si};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q       <= S_IDLE;
            kind_q        <= K_RD;
            bitcnt_q      <= '0;
            sh_q          <= '0;
            addr_sh_q     <= '0;
            ptr_q         <= '0;
            out_sh_q      <= '0;
            outcnt_q      <= '0;
            id_idx_q      <= '0;
            reset_armed_q <= 1'b0;
            so_q          <= 1'b0;
            so_oe_q       <= 1'b0;
            busy_q        <= 1'b0;
            rst_evt_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
        end else begin
            rst_evt_q <= 1'b0;
            cmd_err_q <= 1'b0;
            we_q      <= 1'b0;
            if (ce_s) begin
                // Frame end or abort: any sclk edge this cycle is ignored.
                state_q  <= S_IDLE;
                so_q     <= 1'b0;
                so_oe_q  <= 1'b0;
                busy_q   <= 1'b0;
                bitcnt_q <= '0;
                outcnt_q <= '0;
            end else begin
                busy_q <= 1'b1;
                case (state_q)
                    S_IDLE: begin
                        state_q  <= S_CMD;
                        bitcnt_q <= '0;
                    end
                    S_CMD: if (sclk_rise) begin
                        sh_q     <= byte_in[6:0];
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_q      <= '0;
                            reset_armed_q <= 1'b0;
                            state_q       <= S_IGNORE;
                            case (byte_in)
                                8'h03: begin kind_q <= K_RD;  state_q <= S_ADDR; end
                                8'h02: begin kind_q <= K_WR;  state_q <= S_ADDR; end
                                8'h9F: begin kind_q <= K_ID;  state_q <= S_ADDR; end
`ifdef PSRAM_FAST_READ_EN
                                8'h0B: begin kind_q <= K_FRD; state_q <= S_ADDR; end
`endif
                                8'h66: reset_armed_q <= 1'b1;
                                8'h99: if (reset_armed_q) begin
                                    rst_evt_q <= 1'b1;
                                    ptr_q     <= '0;
                                    outcnt_q  <= '0;
                                end
                                default: cmd_err_q <= 1'b1;
                            endcase
                        end
                    end
                    S_ADDR: if (sclk_rise) begin
                        addr_sh_q <= addr_in[ADDR_W-2:0];
                        bitcnt_q  <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd23) begin
                            bitcnt_q <= '0;
                            ptr_q    <= addr_in;
                            outcnt_q <= '0;
                            id_idx_q <= '0;
                            case (kind_q)
                                K_WR:    state_q <= S_WR;
                                K_ID:    state_q <= S_ID;
                                K_FRD:   state_q <= S_DUMMY;
                                default: state_q <= S_RD;
                            endcase
                        end
                    end
                    S_DUMMY: if (sclk_rise) begin
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_q <= '0;
                            state_q  <= S_RD;
                        end
                    end
                    S_RD, S_ID: if (sclk_fall) begin
                        so_oe_q  <= 1'b1;
                        outcnt_q <= outcnt_q + 3'd1;
                        if (outcnt_q == 3'd0) begin
                            so_q     <= out_byte[7];
                            out_sh_q <= out_byte[6:0];
                        end else begin
                            so_q     <= out_sh_q[6];
                            out_sh_q <= {out_sh_q[5:0], 1'b0};
                        end
                        if (outcnt_q == 3'd7) begin
                            if (state_q == S_RD)
                                ptr_q <= ptr_q + PTR_ONE;
                            else if (id_idx_q != 2'd2)
                                id_idx_q <= id_idx_q + 2'd1;
                        end
                    end
                    S_WR: if (sclk_rise) begin
                        sh_q     <= byte_in[6:0];
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_q <= '0;
                            we_q     <= 1'b1;
                            waddr_q  <= ptr_q;
                            wdata_q  <= byte_in;
                            ptr_q    <= ptr_q + PTR_ONE;
                        end
                    end
                    S_IGNORE: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (we_q)
            mem[waddr_q] <= wdata_q;
    end

    assign so      = so_q;
    assign so_oe   = so_oe_q;
    assign busy    = busy_q;
    assign rst_evt = rst_evt_q;
    assign cmd_err = cmd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_psram_spi_responder.sv
// ============================================================================
//  Module   : tb_psram_spi_responder
//  Purpose  : Scoreboard bench for psram_spi_responder acting as SPI initiator.
//             The fast-read case runs only when PSRAM_FAST_READ_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psram_spi_responder;

    logic sys_clk, sys_reset_n, ce_n, sclk, si;
    logic so, so_oe, busy, rst_evt, cmd_err;

    int n_chk = 0;
    int n_err = 0;
    int n_rst = 0;
    int n_cerr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_sh;
    int mon_n = 0;

    psram_spi_responder dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .ce_n        (ce_n),
        .sclk        (sclk),
        .si          (si),
        .so          (so),
        .so_oe       (so_oe),
        .busy        (busy),
        .rst_evt     (rst_evt),
        .cmd_err     (cmd_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: assemble each data byte the DUT drives and compare against the scoreboard.
    always @(posedge sclk) begin
        if (so_oe === 1'b1) begin
            mon_sh = {mon_sh[6:0], so};
            mon_n++;
            if (mon_n == 8) begin
                mon_n = 0;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_byte actual=%0h required=none", mon_sh);
                end else begin
                    chk("rd_byte", {24'h0, mon_sh}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    always @(posedge ce_n) mon_n = 0;

    always @(negedge sys_clk) begin
        if (rst_evt === 1'b1) n_rst++;
        if (cmd_err === 1'b1) n_cerr++;
    end

    task automatic spi_bit(input logic b, output logic oe);
        si = b;
        repeat (4) @(negedge sys_clk);
        oe = so_oe;
        sclk = 1'b1;
        repeat (4) @(negedge sys_clk);
        sclk = 1'b0;
    endtask

    task automatic xbyte(input logic [7:0] tx, output logic [7:0] oe);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], o);
            oe[i] = o;
        end
    endtask

    task automatic frame_begin();
        ce_n = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic frame_end();
        ce_n = 1'b1;
        repeat (6) @(negedge sys_clk);
    endtask

    task automatic hdr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] oe, acc;
        frame_begin();
        xbyte(op, acc);
        xbyte(a[23:16], oe); acc |= oe;
        xbyte(a[15:8], oe);  acc |= oe;
        xbyte(a[7:0], oe);   acc |= oe;
        chk("oe_hdr", {24'h0, acc}, 32'h0);
    endtask

    task automatic op_frame(input logic [7:0] op);
        logic [7:0] oe;
        frame_begin();
        xbyte(op, oe);
        chk("oe_op", {24'h0, oe}, 32'h0);
        frame_end();
    endtask

    task automatic rd(input int n);
        logic [7:0] oe;
        for (int i = 0; i < n; i++) begin
            xbyte(8'h00, oe);
            chk("oe_data", {24'h0, oe}, 32'hFF);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        logic [7:0] oe;
        xbyte(d, oe);
    endtask

    task automatic drained();
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        int c0, e0;
        logic [7:0] oe, oe2;
        logic o;
        sys_reset_n = 1'b0;
        ce_n = 1'b1;
        sclk = 1'b0;
        si = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset_outs", {27'h0, so, so_oe, busy, rst_evt, cmd_err}, 32'h0);
        sys_reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        e0 = n_cerr;

        // Write/read with upper address bits ignored
        hdr(8'h02, 24'h70F0FE); wr(8'h66); frame_end();
        hdr(8'h03, 24'h70F0FE); exp_q.push_back(8'h66); rd(1); frame_end(); drained();
        hdr(8'h03, 24'h0000FE); exp_q.push_back(8'h66); rd(1); frame_end(); drained();

        // Read ID
        hdr(8'h9F, 24'hFFFFFF);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h5D); exp_q.push_back(8'h00);
        rd(3); frame_end(); drained();

        // Software reset sequencing
        c0 = n_rst; op_frame(8'h66); op_frame(8'h99);
        chk("rst_pair", n_rst - c0, 1);
        c0 = n_rst; op_frame(8'h99);
        chk("rst_alone", n_rst - c0, 0);
        c0 = n_rst; op_frame(8'h66); hdr(8'h03, 24'h000000); frame_end(); op_frame(8'h99);
        chk("rst_broken", n_rst - c0, 0);
        chk("no_cmd_err_yet", n_cerr - e0, 0);

        // Wrap at top of array
        hdr(8'h02, 24'h0000FF); wr(8'hAA); wr(8'hBB); frame_end();
        hdr(8'h03, 24'h000000); exp_q.push_back(8'hBB); rd(1); frame_end(); drained();
        hdr(8'h03, 24'h0000FF); exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); rd(2); frame_end(); drained();

        // Aborted partial write must not commit
        hdr(8'h02, 24'h000010); wr(8'h12); frame_end();
        hdr(8'h02, 24'h000010);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, o);
        chk("busy_mid", {31'h0, busy}, 32'h1);
        ce_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("busy_drop", {31'h0, busy}, 32'h0);
        repeat (4) @(negedge sys_clk);
        hdr(8'h03, 24'h000010); exp_q.push_back(8'h12); rd(1); frame_end(); drained();

        // Unsupported opcode
        c0 = n_cerr;
        frame_begin(); xbyte(8'hA5, oe); xbyte(8'h00, oe2); frame_end();
        chk("oe_ignore", {24'h0, oe | oe2}, 32'h0);
        chk("cmd_err_a5", n_cerr - c0, 1);

`ifdef PSRAM_FAST_READ_EN
        c0 = n_cerr;
        hdr(8'h0B, 24'h0000FE); xbyte(8'h00, oe);
        chk("oe_dummy", {24'h0, oe}, 32'h0);
        exp_q.push_back(8'h66); rd(1); frame_end(); drained();
        chk("cmd_err_0b", n_cerr - c0, 0);
`else
        c0 = n_cerr;
        frame_begin(); xbyte(8'h0B, oe); xbyte(8'h00, oe2); frame_end();
        chk("oe_0b", {24'h0, oe | oe2}, 32'h0);
        chk("cmd_err_0b", n_cerr - c0, 1);
`endif

        // Hardware reset in the middle of read data
        hdr(8'h03, 24'h000010);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, o);
        chk("oe_before_rst", {31'h0, so_oe}, 32'h1);
        sys_reset_n = 1'b0;
        #1;
        chk("rst_mid_read", {30'h0, so_oe, busy}, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        frame_end();
        hdr(8'h03, 24'h000010); exp_q.push_back(8'h12); rd(1); frame_end(); drained();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
